// File: rtl/ping_pong_pkg.sv
// Shared types and defaults for the ping-pong display buffer.
//   nibble_t    : one 4-bit hex digit as stored and displayed
//   rd_state_e  : read-side state (IDLE = nothing shown, SHOW = presenting a bank)
//   DEFAULT_*   : default parameter values for the buffer
package ping_pong_pkg;

  localparam int unsigned DEFAULT_DEPTH       = 8;
  localparam int unsigned DEFAULT_HOLD_CYCLES = 50_000_000;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } rd_state_e;

endpackage

// File: rtl/pp_bank.sv
// One storage bank: DEPTH x nibble_t flops, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   clk     : rising-edge clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module pp_bank
  import ping_pong_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  nibble_t       wdata_i,
  input  logic [AW-1:0] raddr_i,
  output nibble_t       rdata_o
);

  nibble_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ping_pong_buffer.sv
// Two-bank ping-pong buffer feeding a 7-segment decoder. The producer fills
// the write bank; once it is full and the reader is idle the banks swap and
// the reader presents each entry for HOLD_CYCLES clocks, in write order.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   wr_valid : producer offers wr_data
//   wr_data  : nibble to store
//   wr_ready : a write is accepted this cycle
//   rd_data  : nibble currently presented (0 when idle)
//   rd_valid : rd_data is a live buffered entry
//   rd_bank  : index of the bank being read
module ping_pong_buffer
  import ping_pong_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [3:0] wr_data,
  output logic       wr_ready,
  output logic [3:0] rd_data,
  output logic       rd_valid,
  output logic       rd_bank
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
  localparam logic [HW-1:0] LAST_HOLD  = HW'(HOLD_CYCLES - 1);

  logic          wr_bank_q;
  logic [CW-1:0] wr_count_q;
  rd_state_e     state_q;
  logic [AW-1:0] rd_idx_q;
  logic [HW-1:0] hold_cnt_q;

  logic    wr_full;
  logic    wr_accept;
  nibble_t rdata0;
  nibble_t rdata1;

  assign wr_full   = (wr_count_q == FULL_COUNT);
  assign wr_ready  = ~wr_full;
  assign wr_accept = wr_valid & wr_ready;

  pp_bank #(.DEPTH(DEPTH)) u_bank0 (
    .clk     (clk),
    .we_i    (wr_accept & ~wr_bank_q),
    .waddr_i (wr_count_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_idx_q),
    .rdata_o (rdata0)
  );

  pp_bank #(.DEPTH(DEPTH)) u_bank1 (
    .clk     (clk),
    .we_i    (wr_accept & wr_bank_q),
    .waddr_i (wr_count_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_idx_q),
    .rdata_o (rdata1)
  );

  // A write can never coincide with a swap: writes need !wr_full, swaps need wr_full.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q  <= 1'b0;
      wr_count_q <= '0;
      state_q    <= IDLE;
      rd_idx_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      if (wr_accept) wr_count_q <= wr_count_q + CW'(1);
      case (state_q)
        IDLE: begin
          if (wr_full) begin
            wr_bank_q  <= ~wr_bank_q;
            wr_count_q <= '0;
            rd_idx_q   <= '0;
            hold_cnt_q <= '0;
            state_q    <= SHOW;
          end
        end
        SHOW: begin
          if (hold_cnt_q == LAST_HOLD) begin
            hold_cnt_q <= '0;
            if (rd_idx_q == LAST_IDX) state_q  <= IDLE;
            else                      rd_idx_q <= rd_idx_q + AW'(1);
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_bank  = ~wr_bank_q;
  assign rd_valid = (state_q == SHOW);

  always_comb begin
    rd_data = '0;
    if (state_q == SHOW) rd_data = wr_bank_q ? rdata0 : rdata1;
  end

endmodule

// File: tb/tb_ping_pong_buffer.sv
module tb_ping_pong_buffer;
  import ping_pong_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 3;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       rd_bank;

  int n_tests = 0;
  int n_fail  = 0;

  ping_pong_buffer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_bank  (rd_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue for the filling bank, a snapshot of the bank
  // on display and the number of cycles it has been on display.
  nibble_t m_fill [$];
  nibble_t m_show [DEPTH];
  bit      m_wbank;
  bit      m_showing;
  int      m_elapsed;
  bit      m_live = 1'b0;

  always @(posedge clk) begin
    bit acc;
    acc = wr_valid && (m_fill.size() < DEPTH);
    if (reset) begin
      m_fill.delete();
      m_wbank   = 1'b0;
      m_showing = 1'b0;
      m_elapsed = 0;
      m_live    = 1'b1;
    end else if (m_live) begin
      if (m_showing) begin
        m_elapsed++;
        if (m_elapsed == DEPTH * HOLD) m_showing = 1'b0;
      end else if (m_fill.size() == DEPTH) begin
        foreach (m_show[i]) m_show[i] = m_fill[i];
        m_fill.delete();
        m_wbank   = ~m_wbank;
        m_showing = 1'b1;
        m_elapsed = 0;
      end
      if (acc) m_fill.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic       e_ready, e_valid, e_bank;
      logic [3:0] e_data;
      e_ready = (m_fill.size() < DEPTH);
      e_valid = m_showing;
      e_bank  = ~m_wbank;
      e_data  = m_showing ? m_show[m_elapsed / HOLD] : 4'h0;
      n_tests++;
      if (wr_ready !== e_ready || rd_valid !== e_valid || rd_bank !== e_bank || rd_data !== e_data) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got ready=%b valid=%b data=%h bank=%b, expected ready=%b valid=%b data=%h bank=%b",
                 $time, wr_ready, rd_valid, rd_data, rd_bank, e_ready, e_valid, e_data, e_bank);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Offer v and return just after the edge that accepts it.
  task automatic push(input logic [3:0] v, output int waited);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = v;
    waited   = 0;
    while (!wr_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!wr_ready) chk("push_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  nibble_t got_q [$];

  // Called on a negedge; collects rd_data for as long as rd_valid stays high.
  task automatic show_run();
    int guard = 0;
    got_q.delete();
    while (rd_valid && guard < 100) begin
      got_q.push_back(rd_data);
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic chk_seq(input string name, input logic [3:0] v0, input logic [3:0] v1,
                         input logic [3:0] v2, input logic [3:0] v3, input int skip);
    logic [3:0] vals [4];
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    chk({name, "_len"}, got_q.size(), DEPTH * HOLD - skip);
    for (int i = 0; i < got_q.size() && i < DEPTH * HOLD - skip; i++)
      chk({name, "_val"}, got_q[i], vals[(i + skip) / HOLD]);
  endtask

  initial begin
    int w;
    int hi;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 4'h0;

    // Reset state
    do_reset();
    chk("rst_ready", wr_ready, 1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data",  rd_data,  0);
    chk("rst_bank",  rd_bank,  1);

    // Fill and show
    push(4'h1, w); push(4'h2, w); push(4'h3, w); push(4'h4, w);
    idle();
    chk("fs_full_ready", wr_ready, 0);
    chk("fs_pre_valid",  rd_valid, 0);
    @(negedge clk);
    chk("fs_first_data", rd_data, 1);
    chk("fs_bank",       rd_bank, 0);
    chk("model_pin_first", m_show[0], 1);
    show_run();
    chk_seq("fs", 4'h1, 4'h2, 4'h3, 4'h4, 0);
    chk("fs_end_valid", rd_valid, 0);
    chk("fs_end_ready", wr_ready, 1);

    // Backpressure
    do_reset();
    push(4'hA, w); push(4'hB, w); push(4'hC, w); push(4'hD, w);
    push(4'hE, w); push(4'hF, w); push(4'h0, w); push(4'h7, w);
    idle();
    chk("bp_ready_low", wr_ready, 0);
    push(4'h9, w);
    chk("bp_stall_cycles", w, 8);
    idle();
    chk("bp_bank",  rd_bank,  1);
    chk("bp_valid", rd_valid, 1);
    chk("bp_data",  rd_data,  4'hE);
    show_run();
    chk_seq("bp", 4'hE, 4'hF, 4'h0, 4'h7, 1);

    // Coincident finish
    do_reset();
    push(4'h1, w); push(4'h2, w); push(4'h3, w); push(4'h4, w);
    push(4'h5, w); push(4'h6, w); push(4'h7, w);
    idle();
    repeat (7) @(negedge clk);
    push(4'h8, w);
    idle();
    chk("co_gap_valid", rd_valid, 0);
    chk("co_gap_data",  rd_data,  0);
    chk("co_gap_ready", wr_ready, 0);
    @(negedge clk);
    chk("co_new_valid", rd_valid, 1);
    chk("co_new_data",  rd_data,  5);
    chk("co_new_bank",  rd_bank,  1);
    show_run();
    chk_seq("co", 4'h5, 4'h6, 4'h7, 4'h8, 0);

    // Partial fill
    do_reset();
    push(4'h1, w); push(4'h2, w); push(4'h3, w);
    idle();
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_valid) hi++;
    end
    chk("pf_valid_cycles", hi, 0);
    chk("pf_ready", wr_ready, 1);

    // Reset mid-show
    do_reset();
    push(4'h9, w); push(4'h8, w); push(4'h7, w); push(4'h6, w);
    idle();
    @(negedge clk);
    chk("rs_first", rd_data, 9);
    repeat (3) @(negedge clk);
    chk("rs_second", rd_data, 8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rs_valid", rd_valid, 0);
    chk("rs_data",  rd_data,  0);
    chk("rs_ready", wr_ready, 1);
    chk("rs_bank",  rd_bank,  1);

    // Writes with idle gaps
    push(4'h5, w); idle();
    push(4'h6, w); idle();
    push(4'h7, w); idle();
    push(4'h8, w); idle();
    @(negedge clk);
    show_run();
    chk_seq("gap", 4'h5, 4'h6, 4'h7, 4'h8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ping_pong_buffer.md
PING_PONG_BUFFER -- requirements
Module: ping_pong_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entries per bank (power of two, 2..256).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning clocks each read entry is presented (>=1).
REQ-003 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_valid  input  1  producer offers wr_data this cycle.
REQ-006 SHALL have port wr_data  input  4  hex nibble to store.
REQ-007 SHALL have port wr_ready  output  1  buffer accepts a write this cycle.
REQ-008 SHALL have port rd_data  output  4  nibble presented to the downstream 7-segment decoder's data_in.
REQ-009 SHALL have port rd_valid  output  1  rd_data is a live buffered entry.
REQ-010 SHALL have port rd_bank  output  1  index of the bank currently being read.

Function
REQ-011 SHALL hold two banks of DEPTH x 4-bit flop storage; one is the write bank, the other the read bank; rd_bank = NOT write bank.
REQ-012 SHALL accept a write on any edge with wr_valid && wr_ready, storing wr_data at write bank[wr_count] and incrementing wr_count.
REQ-013 SHALL assert wr_full when wr_count == DEPTH; wr_ready = NOT wr_full (combinational from registered state).
REQ-014 SHALL run read FSM with states IDLE and SHOW.
REQ-015 SHALL perform a swap on the edge where wr_full == 1 and read FSM == IDLE: toggle write bank, wr_count <= 0, rd_idx <= 0, hold_cnt <= 0, FSM <= SHOW.
REQ-016 SHALL, in SHOW, increment hold_cnt each edge; at hold_cnt == HOLD_CYCLES-1, clear hold_cnt and increment rd_idx, or go to IDLE if rd_idx == DEPTH-1.
REQ-017 SHALL drive rd_valid = 1 exactly in SHOW, and rd_data = read bank[rd_idx] in SHOW, 4'h0 in IDLE.
REQ-018 SHALL have latency: DEPTH-th write accepted at edge k with FSM IDLE -> swap at edge k+1 -> first entry on rd_data after edge k+1.
REQ-019 SHALL keep writer blocked (wr_ready = 0) while full and read FSM in SHOW; no data is ever dropped or overwritten.
REQ-020 SHALL, when bank fills on the same edge the reader leaves SHOW, swap on the following edge (exactly one IDLE cycle, rd_valid low).
REQ-021 SHALL present each entry for exactly HOLD_CYCLES cycles; a bank is shown for DEPTH*HOLD_CYCLES cycles.
REQ-022 SHALL not reorder data: entries read in write order, index 0 first.
REQ-023 SHALL use counter widths $clog2(DEPTH)+1 for wr_count, $clog2(DEPTH) for rd_idx, $clog2(HOLD_CYCLES)+1 for hold_cnt; no wrap beyond stated limits.

Reset
REQ-024 SHALL, on reset high at an edge, set write bank = 0, wr_count = 0, FSM = IDLE, rd_idx = 0, hold_cnt = 0; outputs: wr_ready = 1, rd_valid = 0, rd_data = 4'h0, rd_bank = 1.
REQ-025 SHALL not clear storage contents on reset; contents are unobservable until rewritten.
REQ-026 SHALL let reset mid-SHOW or mid-fill abort immediately; partial bank discarded; reset dominates a coincident write or swap.

Structure
REQ-027 SHALL place nibble_t (4-bit), read-state enum (IDLE, SHOW) and default DEPTH/HOLD_CYCLES in shared package ping_pong_pkg.
REQ-028 SHALL implement storage as one sub-module pp_bank (DEPTH x nibble_t, one write port, one async read port), instantiated twice.

Verification (DEPTH=4, HOLD_CYCLES=3)
REQ-029 SHALL cover fill-and-show: write 1,2,3,4 back-to-back from reset -> swap next edge; rd_data 1,2,3,4 each 3 cycles, rd_valid high 12 cycles, rd_bank=0.
REQ-030 SHALL cover backpressure: write A,B,C,D then E,F,G,H during show -> wr_ready low after H; 9th write stalls until A..D finish; next swap gives E..H, rd_bank=1.
REQ-031 SHALL cover coincident finish: second bank's 4th write on the edge reader leaves SHOW -> one cycle rd_valid=0, rd_data=0, then new bank shown.
REQ-032 SHALL cover partial fill: write 3 entries only -> wr_ready stays 1, rd_valid stays 0 indefinitely.
REQ-033 SHALL cover reset mid-show: reset during 2nd entry -> next cycle rd_valid=0, rd_data=0, wr_ready=1, rd_bank=1.
REQ-034 SHALL cover idle wr_valid gaps: writes 5,_,6,_,7,_,8 -> read order 5,6,7,8, no lost or duplicated entries.
